// File: rtl/serial_parity_checker.sv
// Receive side of the serial parity link: deserialises start/data/parity/stop frames,
// flags parity and stop-bit errors, and keeps a saturating count of bad frames.
module serial_parity_checker #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x,
    input  logic                 x_valid,
    input  logic                 err_clr,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic            PAR_TGT  = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    state_e                 state_q;
    logic [DATA_W-1:0]      shift_q;
    logic [CNT_W-1:0]       bitcnt_q;
    logic                   acc_q;
    logic                   perr_q;
    logic [DATA_W-1:0]      data_q;
    logic                   dv_q;
    logic                   perr_out_q;
    logic                   ferr_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [ERR_CNT_W-1:0]   err_cnt_d;
    logic                   frame_bad;

    // Frame-level FSM; every output flag is a register updated on the stop strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            acc_q      <= 1'b0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            if (x_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (!x) begin
                            state_q  <= S_DATA;
                            bitcnt_q <= '0;
                            acc_q    <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        shift_q <= {x, shift_q[DATA_W-1:1]};
                        acc_q   <= acc_q ^ x;
                        if (bitcnt_q == LAST_BIT) begin
                            bitcnt_q <= '0;
                            state_q  <= S_PARITY;
                        end else begin
                            bitcnt_q <= bitcnt_q + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        perr_q  <= (acc_q ^ x) != PAR_TGT;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        data_q     <= shift_q;
                        perr_out_q <= perr_q;
                        ferr_q     <= ~x;
                        dv_q       <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign frame_bad = x_valid && (state_q == S_STOP) && (perr_q || !x);

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr)
            err_cnt_d = '0;
        else if (frame_bad && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_cnt_q <= '0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: three configurations share one stimulus stream and
// are checked every cycle against a frame-level model, plus directed literal checks.
module tb_serial_parity_checker;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset, x, x_valid, err_clr;

    logic [DW-1:0] a_data, b_data, c_data;
    logic          a_dv, b_dv, c_dv, a_pe, b_pe, c_pe, a_fe, b_fe, c_fe, a_busy, b_busy, c_busy;
    logic [7:0]    a_cnt, c_cnt;
    logic [1:0]    b_cnt;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(0), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .err_clr(err_clr),
        .data_out(a_data), .data_valid(a_dv), .parity_err(a_pe), .frame_err(a_fe),
        .busy(a_busy), .err_count(a_cnt));

    serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(0), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .err_clr(err_clr),
        .data_out(b_data), .data_valid(b_dv), .parity_err(b_pe), .frame_err(b_fe),
        .busy(b_busy), .err_count(b_cnt));

    serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(1), .ERR_CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .err_clr(err_clr),
        .data_out(c_data), .data_valid(c_dv), .parity_err(c_pe), .frame_err(c_fe),
        .busy(c_busy), .err_count(c_cnt));

    // Frame-level model: collect strobed bits of the current frame in a queue and
    // evaluate the whole frame once start+data+parity+stop have arrived.
    logic          fb[$];
    logic [DW-1:0] m_data = '0;
    logic          m_dv = 1'b0, m_pe_even = 1'b0, m_pe_odd = 1'b0, m_fe = 1'b0, m_busy = 1'b0;
    logic [7:0]    m_cnt_a = '0, m_cnt_c = '0;
    logic [1:0]    m_cnt_b = '0;
    logic          m_done, m_p, m_s;
    int            m_ones;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fb.delete();
            m_data = '0; m_dv = 0; m_pe_even = 0; m_pe_odd = 0; m_fe = 0; m_busy = 0;
            m_cnt_a = '0; m_cnt_b = '0; m_cnt_c = '0;
        end else begin
            m_dv   = 1'b0;
            m_done = 1'b0;
            if (x_valid) begin
                if (fb.size() != 0 || x == 1'b0) fb.push_back(x);
                if (fb.size() == DW + 3) begin
                    for (int i = 0; i < DW; i++) m_data[i] = fb[1 + i];
                    m_p       = fb[DW + 1];
                    m_s       = fb[DW + 2];
                    m_ones    = $countones(m_data) + int'(m_p);
                    m_pe_even = (m_ones % 2) != 0;
                    m_pe_odd  = (m_ones % 2) != 1;
                    m_fe      = !m_s;
                    m_dv      = 1'b1;
                    m_done    = 1'b1;
                    fb.delete();
                end
            end
            if (err_clr) begin
                m_cnt_a = '0; m_cnt_b = '0; m_cnt_c = '0;
            end else if (m_done) begin
                if ((m_pe_even || m_fe) && m_cnt_a != 8'hFF) m_cnt_a = m_cnt_a + 8'd1;
                if ((m_pe_even || m_fe) && m_cnt_b != 2'b11) m_cnt_b = m_cnt_b + 2'd1;
                if ((m_pe_odd  || m_fe) && m_cnt_c != 8'hFF) m_cnt_c = m_cnt_c + 8'd1;
            end
            m_busy = fb.size() != 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a.data_out", 32'(a_data), 32'(m_data));
        chk("a.data_valid", 32'(a_dv), 32'(m_dv));
        chk("a.parity_err", 32'(a_pe), 32'(m_pe_even));
        chk("a.frame_err", 32'(a_fe), 32'(m_fe));
        chk("a.busy", 32'(a_busy), 32'(m_busy));
        chk("a.err_count", 32'(a_cnt), 32'(m_cnt_a));
        chk("b.data_out", 32'(b_data), 32'(m_data));
        chk("b.data_valid", 32'(b_dv), 32'(m_dv));
        chk("b.parity_err", 32'(b_pe), 32'(m_pe_even));
        chk("b.err_count", 32'(b_cnt), 32'(m_cnt_b));
        chk("c.data_out", 32'(c_data), 32'(m_data));
        chk("c.parity_err", 32'(c_pe), 32'(m_pe_odd));
        chk("c.frame_err", 32'(c_fe), 32'(m_fe));
        chk("c.busy", 32'(c_busy), 32'(m_busy));
        chk("c.err_count", 32'(c_cnt), 32'(m_cnt_c));
    end

    logic [DW-1:0] words[$];
    always @(negedge clk) if (a_dv === 1'b1) words.push_back(a_data);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b, input logic clr);
        x = b; x_valid = 1'b1; err_clr = clr;
        tick();
        x_valid = 1'b0; err_clr = 1'b0; x = 1'b1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                              input int gmin, input int gmax, input logic clr_stop);
        logic [DW+2:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < DW + 3; i++) begin
            if (i != 0 && gmax > 0) repeat ($urandom_range(gmax, gmin)) tick();
            strobe(bits[i], (i == DW + 2) ? clr_stop : 1'b0);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic p, s;
        reset = 1'b1; x = 1'b1; x_valid = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        chk("rst.data_out", 32'(a_data), 32'h0);
        chk("rst.err_count", 32'(a_cnt), 32'h0);
        reset = 1'b0;
        repeat (2) strobe(1'b1, 1'b0);

        // Clean even-parity frame
        send_frame(8'hA5, 1'b0, 1'b1, 0, 0, 1'b0);
        settle();
        chk("t1.data_out", 32'(a_data), 32'hA5);
        chk("t1.model_data", 32'(m_data), 32'hA5);
        chk("t1.data_valid", 32'(a_dv), 32'h1);
        chk("t1.parity_err", 32'(a_pe), 32'h0);
        chk("t1.frame_err", 32'(a_fe), 32'h0);
        chk("t1.err_count", 32'(a_cnt), 32'h0);
        settle();
        chk("t1.dv_pulse", 32'(a_dv), 32'h0);
        chk("t1.busy", 32'(a_busy), 32'h0);

        send_frame(8'hA5, 1'b1, 1'b1, 0, 0, 1'b0);
        settle();
        chk("t2.parity_err", 32'(a_pe), 32'h1);
        chk("t2.model_pe", 32'(m_pe_even), 32'h1);
        chk("t2.data_out", 32'(a_data), 32'hA5);
        chk("t2.err_count", 32'(a_cnt), 32'h1);

        send_frame(8'h3C, 1'b0, 1'b0, 0, 0, 1'b0);
        settle();
        chk("t3.frame_err", 32'(a_fe), 32'h1);
        chk("t3.parity_err", 32'(a_pe), 32'h0);
        chk("t3.err_count", 32'(a_cnt), 32'h2);

        // Gapped frame then a back-to-back frame with no dead cycle
        words.delete();
        send_frame(8'h81, 1'b0, 1'b1, 1, 3, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b1, 0, 0, 1'b0);
        settle();
        chk("t4.frames", 32'(words.size()), 32'd2);
        chk("t4.word0", 32'(words[0]), 32'h81);
        chk("t4.word1", 32'(words[1]), 32'h7E);
        chk("t4.err_count", 32'(a_cnt), 32'h2);

        // Reset in the middle of a frame
        words.delete();
        strobe(1'b0, 1'b0);
        repeat (4) strobe(1'b1, 1'b0);
        #2 reset = 1'b1;
        settle();
        chk("t5.busy", 32'(a_busy), 32'h0);
        chk("t5.data_out", 32'(a_data), 32'h0);
        chk("t5.err_count", 32'(a_cnt), 32'h0);
        chk("t5.flags", 32'({a_dv, a_pe, a_fe}), 32'h0);
        tick();
        reset = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 0, 2, 1'b0);
        settle();
        chk("t5.frames", 32'(words.size()), 32'd1);
        chk("t5.word0", 32'(words[0]), 32'h5A);

        // Saturation on the narrow counter, then clear coincident with a bad frame
        repeat (5) send_frame(8'hA5, 1'b1, 1'b1, 0, 1, 1'b0);
        settle();
        chk("t6.sat_b", 32'(b_cnt), 32'h3);
        chk("t6.cnt_a", 32'(a_cnt), 32'h5);
        send_frame(8'hA5, 1'b1, 1'b1, 0, 0, 1'b1);
        settle();
        chk("t6.clr_b", 32'(b_cnt), 32'h0);
        chk("t6.clr_a", 32'(a_cnt), 32'h0);
        send_frame(8'hFF, 1'b1, 1'b1, 0, 0, 1'b0);
        settle();
        chk("t6.odd_pe", 32'(c_pe), 32'h0);
        chk("t6.even_pe", 32'(a_pe), 32'h1);

        // Randomised frames with idle bits, gaps and occasional clears
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) strobe(1'b1, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
            d = DW'($urandom);
            p = ^d ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 9) != 0);
            send_frame(d, p, s, 0, $urandom_range(0, 2), $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
            end
        end
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
